// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor command path: command width, PWM period
// defaults shared with the PWM generator, and sequencer state encoding.
package motor_ctrl_pkg;

  localparam int CMD_W         = 16;
  localparam int DEF_MAX_COUNT = 4000;
  localparam int DEF_CMD_LIMIT = 4000;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DWELL = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  typedef logic signed [CMD_W-1:0] cmd_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; period_tick is registered and is high
// for the single cycle in which the counter holds MAX_COUNT-1.
module pwm_period_timer
  import motor_ctrl_pkg::*;
#(
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic clk,
  input  logic reset_n,
  output logic period_tick
);

  localparam int              CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      period_tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Clamps and slew-limits the PID target into the signed PWM duty command,
// inserting a zero-command dwell after every stop and handling enable/fault.
module motor_cmd_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int MAX_COUNT     = DEF_MAX_COUNT,
  parameter int CMD_LIMIT     = DEF_CMD_LIMIT,
  parameter int SLEW_STEP     = 40,
  parameter int REVERSE_DWELL = 25
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    fault,
  input  logic                    fault_clear,
  input  logic                    target_valid,
  input  logic signed [CMD_W-1:0] target_cmd,
  output logic signed [CMD_W-1:0] pwm_cmd,
  output logic                    period_tick,
  output logic [1:0]              state,
  output logic                    at_target,
  output logic                    fault_latched
);

  localparam int DW_W = (REVERSE_DWELL > 0) ? $clog2(REVERSE_DWELL + 1) : 1;
  localparam logic [DW_W-1:0]     DW_LOAD = DW_W'(REVERSE_DWELL);
  localparam logic [DW_W-1:0]     DW_ONE  = DW_W'(1);
  localparam logic signed [CMD_W:0] LIM_X  = (CMD_W + 1)'(CMD_LIMIT);
  localparam logic signed [CMD_W:0] STEP_X = (CMD_W + 1)'(SLEW_STEP);
  localparam cmd_t LIM_C  = cmd_t'(CMD_LIMIT);
  localparam cmd_t NLIM_C = cmd_t'(-CMD_LIMIT);
  localparam cmd_t STEP_C = cmd_t'(SLEW_STEP);

  // Saturate to +/-CMD_LIMIT; widened so -32768 compares correctly.
  function automatic cmd_t clamp_cmd(input cmd_t v);
    logic signed [CMD_W:0] v_x;
    v_x = {v[CMD_W-1], v};
    if (v_x > LIM_X)       clamp_cmd = LIM_C;
    else if (v_x < -LIM_X) clamp_cmd = NLIM_C;
    else                   clamp_cmd = v;
  endfunction

  // One slew step toward eff; the difference is formed at CMD_W+1 bits.
  function automatic cmd_t slew_toward(input cmd_t cur, input cmd_t eff);
    logic signed [CMD_W:0] diff;
    diff = {eff[CMD_W-1], eff} - {cur[CMD_W-1], cur};
    if (diff > STEP_X)       slew_toward = cur + STEP_C;
    else if (diff < -STEP_X) slew_toward = cur - STEP_C;
    else                     slew_toward = eff;
  endfunction

  cmd_t            tgt;
  cmd_t            tgt_nxt;
  cmd_t            pwm_nxt;
  cmd_t            eff;
  logic [1:0]      state_nxt;
  logic [DW_W-1:0] dwell_cnt;
  logic [DW_W-1:0] dwell_nxt;
  logic            at_nxt;

  pwm_period_timer #(
    .MAX_COUNT (MAX_COUNT)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .period_tick (period_tick)
  );

  always_comb begin
    state_nxt = state;
    pwm_nxt   = pwm_cmd;
    tgt_nxt   = tgt;
    dwell_nxt = dwell_cnt;
    eff       = tgt;

    if (target_valid && (state != ST_FAULT)) tgt_nxt = clamp_cmd(target_cmd);

    if (fault) begin
      state_nxt = ST_FAULT;
      pwm_nxt   = '0;
    end else if (state == ST_FAULT) begin
      pwm_nxt = '0;
      if (fault_clear) state_nxt = ST_IDLE;
    end else if (!enable) begin
      state_nxt = ST_IDLE;
      pwm_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_RUN;
          pwm_nxt   = '0;
        end
        ST_RUN: begin
          if (period_tick) begin
            // A sign reversal is forced through zero so the dwell always runs.
            if ((pwm_cmd != '0) && (tgt != '0) && (pwm_cmd[CMD_W-1] != tgt[CMD_W-1]))
              eff = '0;
            pwm_nxt = slew_toward(pwm_cmd, eff);
            if ((pwm_cmd != '0) && (pwm_nxt == '0)) begin
              state_nxt = ST_DWELL;
              dwell_nxt = DW_LOAD;
            end
          end
        end
        ST_DWELL: begin
          pwm_nxt = '0;
          if (period_tick) begin
            if (dwell_cnt <= DW_ONE) begin
              state_nxt = ST_RUN;
              dwell_nxt = '0;
            end else begin
              dwell_nxt = dwell_cnt - 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          pwm_nxt   = '0;
        end
      endcase
    end

    at_nxt = (state_nxt == ST_RUN) && (pwm_nxt == tgt_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      pwm_cmd       <= '0;
      tgt           <= '0;
      dwell_cnt     <= '0;
      at_target     <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state         <= state_nxt;
      pwm_cmd       <= pwm_nxt;
      tgt           <= tgt_nxt;
      dwell_cnt     <= dwell_nxt;
      at_target     <= at_nxt;
      fault_latched <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Scoreboard bench for motor_cmd_sequencer: a per-cycle reference model
// queues expected outputs, a monitor pops and compares on the falling edge.
module tb_motor_cmd_sequencer;
  import motor_ctrl_pkg::*;

  localparam int MC    = 32;
  localparam int LIM   = 4000;
  localparam int SLEW  = 40;
  localparam int DWELL = 25;
  localparam int S_IDLE = 0, S_RUN = 1, S_DWELL = 2, S_FAULT = 3;

  logic              clk          = 1'b0;
  logic              reset_n      = 1'b0;
  logic              enable       = 1'b0;
  logic              fault        = 1'b0;
  logic              fault_clear  = 1'b0;
  logic              target_valid = 1'b0;
  logic signed [15:0] target_cmd  = '0;
  logic signed [15:0] pwm_cmd;
  logic              period_tick;
  logic [1:0]        state;
  logic              at_target;
  logic              fault_latched;

  motor_cmd_sequencer #(
    .MAX_COUNT     (MC),
    .CMD_LIMIT     (LIM),
    .SLEW_STEP     (SLEW),
    .REVERSE_DWELL (DWELL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .fault         (fault),
    .fault_clear   (fault_clear),
    .target_valid  (target_valid),
    .target_cmd    (target_cmd),
    .pwm_cmd       (pwm_cmd),
    .period_tick   (period_tick),
    .state         (state),
    .at_target     (at_target),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  typedef struct {int pwm; int st; bit at; bit tick;} exp_t;
  typedef struct {string name; int pwm; int st; bit at;} dir_t;

  exp_t sb[$];
  dir_t dq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int clamp_ref(input int v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  // Reference model: works on plain integers and tick counts.
  initial begin : model
    exp_t e;
    int m_pwm, m_st, m_tgt, m_dwell, m_pc;
    int new_tgt, eff, d, mag, old;
    bit tick_now;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_pwm = 0; m_st = S_IDLE; m_tgt = 0; m_dwell = 0; m_pc = 0;
        e = '{0, S_IDLE, 1'b0, 1'b0};
      end else begin
        tick_now = (m_pc == MC - 1);
        new_tgt  = m_tgt;
        if (target_valid && m_st != S_FAULT) new_tgt = clamp_ref(int'(target_cmd));
        if (fault) begin
          m_st = S_FAULT; m_pwm = 0;
        end else if (m_st == S_FAULT) begin
          m_pwm = 0;
          if (fault_clear) m_st = S_IDLE;
        end else if (!enable) begin
          m_st = S_IDLE; m_pwm = 0;
        end else if (m_st == S_IDLE) begin
          m_st = S_RUN;
        end else if (m_st == S_DWELL) begin
          if (tick_now) begin
            m_dwell--;
            if (m_dwell <= 0) m_st = S_RUN;
          end
        end else if (tick_now) begin
          eff = (m_pwm * m_tgt < 0) ? 0 : m_tgt;
          d   = eff - m_pwm;
          mag = (d < 0) ? -d : d;
          if (mag > SLEW) mag = SLEW;
          old   = m_pwm;
          m_pwm = m_pwm + ((d < 0) ? -mag : mag);
          if (old != 0 && m_pwm == 0) begin
            m_st = S_DWELL; m_dwell = DWELL;
          end
        end
        m_tgt = new_tgt;
        m_pc  = (m_pc + 1) % MC;
        e = '{m_pwm, m_st, (m_st == S_RUN && m_pwm == m_tgt), (m_pc == MC - 1)};
      end
      sb.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    dir_t dr;
    @(posedge clk);
    forever begin
      @(negedge clk or negedge reset_n);
      if (clk) begin
        // Reset landed during the high phase: outputs must clear without a clock.
        #1;
        checks++;
        if (pwm_cmd !== 16'sd0 || state !== 2'b00 || at_target !== 1'b0 ||
            fault_latched !== 1'b0 || period_tick !== 1'b0) begin
          errors++;
          $display("FAIL async_reset t=%0t got pwm=%0d state=%0d at=%b fl=%b tick=%b, want all zero",
                   $time, pwm_cmd, state, at_target, fault_latched, period_tick);
        end
        if (sb.size() > 0) void'(sb.pop_front());
        e = '{0, S_IDLE, 1'b0, 1'b0};
        sb.push_front(e);
      end else begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty t=%0t", $time);
        end else begin
          e = sb.pop_front();
          if ($isunknown({pwm_cmd, state, at_target, fault_latched, period_tick}) ||
              int'(pwm_cmd) != e.pwm || int'(state) != e.st || at_target != e.at ||
              fault_latched != (e.st == S_FAULT) || period_tick != e.tick) begin
            errors++;
            $display("FAIL sb t=%0t pwm got %0d want %0d, state got %0d want %0d, at got %b want %b, fl got %b, tick got %b want %b",
                     $time, pwm_cmd, e.pwm, state, e.st, at_target, e.at, fault_latched, period_tick, e.tick);
          end
        end
        if (dq.size() > 0) begin
          dr = dq.pop_front();
          checks++;
          if (int'(pwm_cmd) != dr.pwm || int'(state) != dr.st || at_target != dr.at) begin
            errors++;
            $display("FAIL %s t=%0t pwm got %0d want %0d, state got %0d want %0d, at got %b want %b",
                     dr.name, $time, pwm_cmd, dr.pwm, state, dr.st, at_target, dr.at);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    target_valid = 1'b1;
    target_cmd   = 16'(v);
    cyc();
    target_valid = 1'b0;
  endtask

  task automatic wait_tick_high();
    for (int i = 0; i < 2 * MC; i++) begin
      if (period_tick) return;
      cyc();
    end
    $display("FAIL tick_timeout t=%0t no period_tick within %0d cycles", $time, 2 * MC);
    $fatal(1, "period_tick missing");
  endtask

  task automatic slew_edge();
    wait_tick_high();
    cyc();
  endtask

  task automatic expect_now(input string n, input int p, input int s, input bit a);
    dir_t dr;
    dr = '{n, p, s, a};
    dq.push_back(dr);
  endtask

  initial begin : stim
    repeat (4) cyc();
    expect_now("reset_idle", 0, S_IDLE, 1'b0);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Ramp up to 400, then back to 0 into the dwell
    strobe(400);
    for (int i = 1; i <= 10; i++) begin
      slew_edge();
      expect_now("ramp_up", 40 * i, S_RUN, i == 10);
    end
    strobe(0);
    for (int i = 1; i <= 10; i++) begin
      slew_edge();
      expect_now("ramp_down", 400 - 40 * i, (i == 10) ? S_DWELL : S_RUN, 1'b0);
    end
    repeat (5) slew_edge();

    // Asynchronous reset in the middle of the dwell
    #1;
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    expect_now("post_reset_idle", 0, S_IDLE, 1'b0);
    enable = 1'b1;

    strobe(130);
    for (int i = 1; i <= 4; i++) begin
      slew_edge();
      expect_now("ramp_130", (i == 4) ? 130 : 40 * i, S_RUN, i == 4);
    end

    // Reversal 400 -> -200 with the strobe landing on the tick cycle
    strobe(400);
    for (int i = 1; i <= 7; i++) begin
      slew_edge();
      expect_now("ramp_400", (i == 7) ? 400 : 130 + 40 * i, S_RUN, i == 7);
    end
    wait_tick_high();
    target_valid = 1'b1;
    target_cmd   = -16'sd200;
    cyc();
    target_valid = 1'b0;
    expect_now("same_cycle_strobe", 400, S_RUN, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      slew_edge();
      expect_now("rev_down", 400 - 40 * i, (i == 10) ? S_DWELL : S_RUN, 1'b0);
    end
    for (int i = 1; i <= 25; i++) begin
      slew_edge();
      expect_now("rev_dwell", 0, (i == 25) ? S_RUN : S_DWELL, 1'b0);
    end
    for (int i = 1; i <= 5; i++) begin
      slew_edge();
      expect_now("rev_up", -40 * i, S_RUN, i == 5);
    end

    // Clamp at both ends
    strobe(-32768);
    repeat (95) slew_edge();
    expect_now("clamp_neg", -4000, S_RUN, 1'b1);
    strobe(5000);
    repeat (225) slew_edge();
    expect_now("clamp_pos", 4000, S_RUN, 1'b1);

    // Fault while ramping down through 1200
    strobe(0);
    repeat (70) slew_edge();
    expect_now("at_1200", 1200, S_RUN, 1'b0);
    fault = 1'b1;
    cyc();
    expect_now("fault_entry", 0, S_FAULT, 1'b0);
    fault_clear = 1'b1;
    cyc();
    fault_clear = 1'b0;
    expect_now("clear_ignored", 0, S_FAULT, 1'b0);
    cyc();
    fault       = 1'b0;
    fault_clear = 1'b1;
    cyc();
    fault_clear = 1'b0;
    expect_now("fault_exit", 0, S_IDLE, 1'b0);
    strobe(2000);
    slew_edge();
    expect_now("ramp_again", 40, S_RUN, 1'b0);
    repeat (19) slew_edge();
    expect_now("at_800", 800, S_RUN, 1'b0);

    // Disable drops straight to IDLE; ticks keep running
    enable = 1'b0;
    cyc();
    expect_now("disable", 0, S_IDLE, 1'b0);
    repeat (3 * MC) cyc();

    // Randomized operation
    enable = 1'b1;
    for (int c = 0; c < 38000; c++) begin
      int r;
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      if (!fault) fault = ($urandom_range(0, 1499) == 0);
      else        fault = ($urandom_range(0, 19) != 0);
      fault_clear  = ($urandom_range(0, 29) == 0);
      target_valid = ($urandom_range(0, 23) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      target_cmd = -16'sd32768;
      else if (r == 1) target_cmd = 16'sd32767;
      else if (r == 2) target_cmd = 16'($urandom);
      else             target_cmd = 16'($urandom_range(0, 1200)) - 16'sd600;
      cyc();
    end
    target_valid = 1'b0;
    fault_clear  = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sequencer.md
# motor_cmd_sequencer

Sequences the signed duty command fed to the bidirectional PWM generator. It takes the PID controller's target, clamps it, and slew-limits it once per PWM period. Every stop gets a zero-command dwell before the motor can run again, which gives a safe direction reversal. It also handles enable and fault so the PWM stage never sees abrupt reversals or commands that are out of range. It sits between the PID block and the PWM generator, and its `pwm_cmd` output drives the PWM generator's control input directly.

## Interface
- `MAX_COUNT`, 4000: PWM period in clk cycles; must match the PWM generator (25 kHz at 100 MHz).
- `CMD_LIMIT`, 4000: magnitude clamp for the command, ≤ `MAX_COUNT`.
- `SLEW_STEP`, 40: maximum change in |`pwm_cmd`| per period.
- `REVERSE_DWELL`, 25: number of periods `pwm_cmd` is held at 0 after a stop (1 ms).
- `clk`, input, 1: system clock, 100 MHz.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `enable`, input, 1: run request, level.
- `fault`, input, 1: fault request, synchronous level.
- `fault_clear`, input, 1: one-cycle pulse that clears a latched fault.
- `target_valid`, input, 1: one-cycle strobe; latch `target_cmd`.
- `target_cmd`, input, 16 signed: requested command.
- `pwm_cmd`, output, 16 signed: slewed command to the PWM generator.
- `period_tick`, output, 1: one-cycle pulse at each period end.
- `state`, output, 2: 00 IDLE, 01 RUN, 10 DWELL, 11 FAULT.
- `at_target`, output, 1: `state`==RUN and `pwm_cmd`==`tgt`.
- `fault_latched`, output, 1: high while in FAULT.

## Operation
- **Period counter:** counts 0..`MAX_COUNT`-1, then wraps. `period_tick`=1 when the counter is `MAX_COUNT`-1. The counter free-runs in every state.
- **Target latch:** when `target_valid` is high, `tgt` <= clamp(`target_cmd`, -`CMD_LIMIT`, +`CMD_LIMIT`). -32768 clamps to -`CMD_LIMIT`. The latch is accepted in all states except FAULT. `tgt` resets to 0.
- **Priority per cycle:** fault > !enable > state logic.
- **IDLE:** `pwm_cmd`=0. Go to RUN when `enable`=1. No dwell on this transition.
- **RUN, on each `period_tick`:**
  - Effective target `eff` = 0 if `pwm_cmd` and `tgt` are nonzero with opposite signs, otherwise `tgt`.
  - `pwm_cmd` moves toward `eff` by min(|`eff`-`pwm_cmd`|, `SLEW_STEP`). The difference is computed at 17 bits; no overflow is allowed.
  - If that step takes `pwm_cmd` from nonzero to 0, go to DWELL and load the dwell counter with `REVERSE_DWELL`.
- **DWELL:** `pwm_cmd`=0. The counter decrements on each `period_tick`. The tick that reaches 0 returns to RUN. The dwell always completes, even if `tgt` becomes 0 or changes sign.
- **FAULT:**
  - Entered from any state when `fault`=1.
  - `pwm_cmd`=0.
  - Exit to IDLE only on `fault_clear`=1 while `fault`=0. `fault_clear` while `fault`=1 is ignored.
- **Disable:** `enable`=0 in RUN or DWELL forces IDLE with `pwm_cmd`=0.
- **Simultaneous events:** a `target_valid` on the same cycle as `period_tick` is latched, and the slew step that cycle uses the old `tgt`.

## Timing
- **Reset values:** `pwm_cmd`=0, `period_tick`=0, `state`=IDLE, `at_target`=0, `fault_latched`=0, period counter=0. Reset asserted mid-operation returns all of these immediately, asynchronously.
- **Outputs:** all outputs are registered.
- **Slew updates:** `pwm_cmd` changes on the clock edge at which `period_tick` is high.
- **Fault and disable:** `pwm_cmd`=0 and the new `state` appear on the first clk edge after `fault` or `!enable` is sampled. This forced zero is not aligned to `period_tick`.
- **Target latency:** one cycle from the `target_valid` edge to `tgt`. The first slew effect appears at the next `period_tick`.
- **`at_target`:** updates on the same edge as `pwm_cmd`.

## Structure
- **Package `motor_ctrl_pkg`:**
  - state encoding constants (IDLE/RUN/DWELL/FAULT)
  - `CMD_W`=16
  - default `MAX_COUNT` / `CMD_LIMIT`, shared with the PWM generator so both always use the same period.
- **Sub-module `pwm_period_timer`:** period counter plus `period_tick`, parameterized by `MAX_COUNT`. It is reusable for synchronizing the PID sample rate.

## Test plan
All scenarios use default parameters.
- **Ramp up:** reset, `enable`=1, `target_cmd`=400 strobed -> `pwm_cmd`=40, 80, … 400 on ticks 1–10; `at_target`=1 after tick 10. Then target 130 from 0 -> 40, 80, 120, 130.
- **Reversal:** at 400, target -200 -> 10 ticks down to 0, DWELL for 25 ticks with `pwm_cmd`=0, then -40 … -200 over 5 ticks.
- **Clamp:** `target_cmd`=16'sh8000 -> `tgt`=-4000. `target_cmd`=5000 -> `tgt`=4000. Ramp to 4000 ends at exactly 4000.
- **Fault mid-ramp:**
  - At `pwm_cmd`=1200, `fault`=1 -> next edge `pwm_cmd`=0, `state`=11, `fault_latched`=1.
  - `fault_clear` with `fault`=1 -> stays in FAULT.
  - `fault`=0 plus `fault_clear` -> IDLE; then RUN ramps again from 0.
- **Disable:** `enable`=0 at `pwm_cmd`=800 -> next edge `pwm_cmd`=0, IDLE; `period_tick` continues every 4000 cycles.
- **Reset mid-DWELL:** `reset_n` low -> all outputs at reset values without waiting for a clock; after release, `state`=IDLE.
